// File: rtl/mem_d_copy_engine_if.sv
// Data-port memory request/response bundle between an initiator (master)
// and a TCM/data responder (slave).
interface mem_d_copy_engine_if;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic        rd;
    logic [3:0]  wr;
    logic        cacheable;
    logic [10:0] req_tag;
    logic        invalidate;
    logic        writeback;
    logic        flush;
    logic [31:0] data_rd;
    logic        accept;
    logic        ack;
    logic        error;
    logic [10:0] resp_tag;

    modport master (
        output addr, data_wr, rd, wr, cacheable, req_tag, invalidate, writeback, flush,
        input  data_rd, accept, ack, error, resp_tag
    );

    modport slave (
        input  addr, data_wr, rd, wr, cacheable, req_tag, invalidate, writeback, flush,
        output data_rd, accept, ack, error, resp_tag
    );
endinterface

// File: rtl/mem_d_copy_engine.sv
// Word-granular block COPY/FILL engine driving the data-port memory protocol,
// one request outstanding at a time, with tag/error checking and an ack timeout.
module mem_d_copy_engine #(
    parameter int TIMEOUT = 256,
    parameter int LEN_W   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic [31:0]          src_addr_i,
    input  logic [31:0]          dst_addr_i,
    input  logic [LEN_W-1:0]     len_i,
    input  logic [31:0]          fill_data_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic [LEN_W-1:0]     words_done_o,
    mem_d_copy_engine_if.master  mem_d
);

    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_WR_REQ,
        S_WR_WAIT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_mode;
    logic [31:0]      r_src;
    logic [31:0]      r_dst;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_wordsDone;
    logic [31:0]      r_wrData;
    logic [31:0]      r_addr;
    logic             r_rd;
    logic [3:0]       r_wr;
    logic [10:0]      r_tag;
    logic [10:0]      r_outTag;
    logic [TMR_W-1:0] r_timer;
    logic             r_busy;
    logic             r_done;
    logic             r_error;

    logic [LEN_W-1:0] w_wordsNext;
    logic [31:0]      w_srcNext;
    logic [31:0]      w_dstNext;
    logic             w_respBad;

    assign w_wordsNext = r_wordsDone + LEN_W'(1);
    assign w_srcNext   = r_src + 32'd4;
    assign w_dstNext   = r_dst + 32'd4;
    assign w_respBad   = (mem_d.resp_tag != r_outTag) || mem_d.error;

    // Request fields are loaded on entry to a REQ state and dropped on the accepting edge,
    // so they stay stable for as long as the responder stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_wordsDone <= '0;
            r_wrData    <= '0;
            r_addr      <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 4'h0;
            r_tag       <= '0;
            r_outTag    <= '0;
            r_timer     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_error     <= 1'b0;
                        r_busy      <= 1'b1;
                        r_mode      <= mode_i;
                        r_src       <= src_addr_i & ~32'h3;
                        r_dst       <= dst_addr_i & ~32'h3;
                        r_len       <= len_i;
                        r_wordsDone <= '0;
                        r_wrData    <= fill_data_i;
                        if (len_i == '0) begin
                            r_state <= S_DONE;
                        end else if (mode_i) begin
                            r_state <= S_WR_REQ;
                            r_wr    <= 4'hF;
                            r_addr  <= dst_addr_i & ~32'h3;
                        end else begin
                            r_state <= S_RD_REQ;
                            r_rd    <= 1'b1;
                            r_addr  <= src_addr_i & ~32'h3;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (mem_d.accept) begin
                        r_rd     <= 1'b0;
                        r_outTag <= r_tag;
                        r_tag    <= r_tag + 11'd1;
                        r_timer  <= '0;
                        r_state  <= S_RD_WAIT;
                    end
                end
                S_WR_REQ: begin
                    if (mem_d.accept) begin
                        r_wr     <= 4'h0;
                        r_outTag <= r_tag;
                        r_tag    <= r_tag + 11'd1;
                        r_timer  <= '0;
                        r_state  <= S_WR_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_d.ack) begin
                        if (w_respBad) begin
                            r_error <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_wrData <= mem_d.data_rd;
                            r_wr     <= 4'hF;
                            r_addr   <= r_dst;
                            r_state  <= S_WR_REQ;
                        end
                    end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WR_WAIT: begin
                    if (mem_d.ack) begin
                        if (w_respBad) begin
                            r_error <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_wordsDone <= w_wordsNext;
                            r_src       <= w_srcNext;
                            r_dst       <= w_dstNext;
                            if (w_wordsNext == r_len) begin
                                r_state <= S_DONE;
                            end else if (r_mode) begin
                                r_wr    <= 4'hF;
                                r_addr  <= w_dstNext;
                                r_state <= S_WR_REQ;
                            end else begin
                                r_rd    <= 1'b1;
                                r_addr  <= w_srcNext;
                                r_state <= S_RD_REQ;
                            end
                        end
                    end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                        r_error <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o       = r_busy;
    assign done_o       = r_done;
    assign error_o      = r_error;
    assign words_done_o = r_wordsDone;

    assign mem_d.addr       = r_addr;
    assign mem_d.data_wr    = r_wrData;
    assign mem_d.rd         = r_rd;
    assign mem_d.wr         = r_wr;
    assign mem_d.cacheable  = 1'b1;
    assign mem_d.req_tag    = r_tag;
    assign mem_d.invalidate = 1'b0;
    assign mem_d.writeback  = 1'b0;
    assign mem_d.flush      = 1'b0;

endmodule

// File: tb/tb_mem_d_copy_engine.sv
// Self-checking bench for mem_d_copy_engine: a TCM responder model with stall,
// tag-corruption, error and no-ack knobs, plus a write scoreboard.
module tb_mem_d_copy_engine;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [31:0] srcAddr = '0;
    logic [31:0] dstAddr = '0;
    logic [15:0] len = '0;
    logic [31:0] fillData = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] wordsDone;

    mem_d_copy_engine_if memIf();

    mem_d_copy_engine #(.TIMEOUT(8), .LEN_W(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .mode_i       (mode),
        .src_addr_i   (srcAddr),
        .dst_addr_i   (dstAddr),
        .len_i        (len),
        .fill_data_i  (fillData),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .words_done_o (wordsDone),
        .mem_d        (memIf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         expQ[$];
    logic [31:0] tcm [0:1023];
    int          testsRun = 0;
    int          testsFailed = 0;
    int          cyc = 0;
    int          reqCount = 0;
    int          startCyc = 0;
    logic        acceptEn = 1'b1;
    logic        ackEn = 1'b1;
    logic        tagCorrupt = 1'b0;
    logic        errInject = 1'b0;
    logic        respPending = 1'b0;
    logic [10:0] respTag = '0;
    logic [31:0] respData = '0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        if (obs !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Responder bookkeeping on the clock edge: perform the memory access and score writes.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            respPending = 1'b0;
        end else begin
            if (memIf.ack) respPending = 1'b0;
            if (memIf.accept) begin
                reqCount++;
                respTag     = memIf.req_tag;
                respPending = 1'b1;
                if (memIf.rd) begin
                    respData = tcm[memIf.addr[11:2]];
                end else begin
                    tcm[memIf.addr[11:2]] = memIf.data_wr;
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedWrite", 32'd1, 32'd0);
                    end else begin
                        wr_t e;
                        e = expQ.pop_front();
                        checkOutput("wrAddr", memIf.addr, e.addr);
                        checkOutput("wrData", memIf.data_wr, e.data);
                    end
                end
            end
        end
    end

    // Responder drive on the falling edge so the DUT sees stable inputs at the next rising edge.
    always @(negedge clk) begin
        memIf.accept   = rst_n && acceptEn && !respPending && (memIf.rd || memIf.wr == 4'hF);
        memIf.ack      = rst_n && respPending && ackEn;
        memIf.resp_tag = respTag ^ {10'd0, tagCorrupt};
        memIf.error    = errInject;
        memIf.data_rd  = respData;
    end

    task automatic applyStimulus(input logic m, input logic [31:0] s, input logic [31:0] d,
                                 input logic [15:0] n, input logic [31:0] f, input int nWrites);
        for (int i = 0; i < nWrites; i++) begin
            wr_t e;
            e.addr = d + 32'(4 * i);
            e.data = m ? f : tcm[(s >> 2) + 32'(i)];
            expQ.push_back(e);
        end
        @(negedge clk);
        mode = m; srcAddr = s; dstAddr = d; len = n; fillData = f; start = 1'b1;
        @(posedge clk);
        #1;
        startCyc = cyc;
        start = 1'b0;
        srcAddr = 32'hDEAD_BEEF; dstAddr = 32'hDEAD_BEEF; len = 16'hFFFF; fillData = 32'h0;
    endtask

    task automatic waitDone(input string name, input int expLat, input logic expErr, input logic [15:0] expWords);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) begin
            checkOutput({name, ".doneSeen"}, 32'd0, 32'd1);
        end else begin
            checkOutput({name, ".latency"}, 32'(cyc - startCyc), 32'(expLat));
            checkOutput({name, ".error"}, 32'(error), 32'(expErr));
            checkOutput({name, ".wordsDone"}, 32'(wordsDone), 32'(expWords));
            checkOutput({name, ".busyAfter"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int reqBefore;
        for (int i = 0; i < 1024; i++) tcm[i] = 32'h0;
        tcm[0] = 32'h11; tcm[1] = 32'h22; tcm[2] = 32'h33; tcm[3] = 32'h44;

        repeat (3) @(negedge clk);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        checkOutput("rst.done", 32'(done), 32'd0);
        checkOutput("rst.error", 32'(error), 32'd0);
        checkOutput("rst.rd", 32'(memIf.rd), 32'd0);
        checkOutput("rst.wr", 32'(memIf.wr), 32'd0);
        checkOutput("rst.cacheable", 32'(memIf.cacheable), 32'd1);
        checkOutput("rst.tag", 32'(memIf.req_tag), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        applyStimulus(1'b1, 32'h0, 32'h100, 16'd3, 32'hA5A5_A5A5, 3);
        waitDone("fill3", 7, 1'b0, 16'd3);
        for (int i = 0; i < 3; i++) checkOutput("fill3.mem", tcm[64 + i], 32'hA5A5_A5A5);

        applyStimulus(1'b0, 32'h0, 32'h200, 16'd4, 32'h0, 4);
        waitDone("copy4", 17, 1'b0, 16'd4);
        for (int i = 0; i < 4; i++) checkOutput("copy4.mem", tcm[128 + i], 32'(8'h11 * (i + 1)));
        checkOutput("copy4.tag", 32'(memIf.req_tag), 32'd11);

        reqBefore = reqCount;
        applyStimulus(1'b0, 32'h0, 32'h300, 16'd0, 32'h0, 0);
        waitDone("len0", 1, 1'b0, 16'd0);
        checkOutput("len0.requests", 32'(reqCount - reqBefore), 32'd0);

        acceptEn = 1'b0;
        reqBefore = reqCount;
        applyStimulus(1'b0, 32'h4, 32'h300, 16'd1, 32'h0, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall.rd", 32'(memIf.rd), 32'd1);
            checkOutput("stall.addr", memIf.addr, 32'h4);
            checkOutput("stall.tag", 32'(memIf.req_tag), 32'd11);
        end
        @(posedge clk);
        #1;
        acceptEn = 1'b1;
        waitDone("stall", 10, 1'b0, 16'd1);
        checkOutput("stall.requests", 32'(reqCount - reqBefore), 32'd2);
        checkOutput("stall.mem", tcm[192], 32'h22);

        tagCorrupt = 1'b1;
        applyStimulus(1'b1, 32'h0, 32'h380, 16'd3, 32'h1234_5678, 1);
        waitDone("badTag", 3, 1'b1, 16'd0);
        tagCorrupt = 1'b0;
        applyStimulus(1'b1, 32'h0, 32'h400, 16'd1, 32'h0000_005A, 1);
        waitDone("clearErr", 3, 1'b0, 16'd1);

        errInject = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h480, 16'd2, 32'h0, 0);
        waitDone("respErr", 3, 1'b1, 16'd0);
        errInject = 1'b0;

        ackEn = 1'b0;
        applyStimulus(1'b1, 32'h0, 32'h500, 16'd2, 32'hCAFE_F00D, 1);
        waitDone("timeout", 10, 1'b1, 16'd0);
        ackEn = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idleAck.busy", 32'(busy), 32'd0);
        checkOutput("idleAck.error", 32'(error), 32'd1);

        applyStimulus(1'b0, 32'h0, 32'h600, 16'd4, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midRst.busy", 32'(busy), 32'd0);
        checkOutput("midRst.wr", 32'(memIf.wr), 32'd0);
        checkOutput("midRst.rd", 32'(memIf.rd), 32'd0);
        checkOutput("midRst.addr", memIf.addr, 32'd0);
        checkOutput("midRst.tag", 32'(memIf.req_tag), 32'd0);
        checkOutput("midRst.cacheable", 32'(memIf.cacheable), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(1'b1, 32'h0, 32'h700, 16'd2, 32'h0BAD_CAFE, 2);
        waitDone("recover", 5, 1'b0, 16'd2);
        checkOutput("recover.tag", 32'(memIf.req_tag), 32'd2);
        checkOutput("sbEmpty", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
